onehot_register_bank: RTL

//   64-entry register bank written through a one-hot write-select vector, the

---
 rtl/onehot_register_bank.sv | 135 +++++++++++++
 1 files changed

// File: rtl/onehot_register_bank.sv
// 64-entry register bank written through a one-hot select from the 1:64 write demux.
// Two registered read ports with write-first bypass, plus multi-hot select detection.
module ohrb_entry #(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q,
    output logic              written
);
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q       <= '0;
            written <= 1'b0;
        end else if (we) begin
            q       <= wdata;
            written <= 1'b1;
        end
    end
endmodule

module ohrb_rdport #(
    parameter int N      = 64,
    parameter int DATA_W = 64,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 31
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [5:0]                 addr,
    input  logic [N-1:0][DATA_W-1:0]   ent_q,
    input  logic [N-1:0]               ent_wr,
    input  logic                       byp_en,
    input  logic [5:0]                 byp_idx,
    input  logic [DATA_W-1:0]          byp_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_vld
);
    localparam logic [5:0] ZIDX = 6'(ZERO_IDX);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else if (byp_en && byp_idx == addr) begin
            rd_data <= byp_data;
            rd_vld  <= 1'b1;
        end else if (ZERO_EN != 0 && addr == ZIDX) begin
            rd_data <= '0;
            rd_vld  <= 1'b1;
        end else begin
            rd_data <= ent_q[addr];
            rd_vld  <= ent_wr[addr];
        end
    end
endmodule

module onehot_register_bank #(
    parameter int DATA_W   = 64,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 31,
    parameter int ERRCNT_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [63:0]         WR_SEL,
    input  logic [DATA_W-1:0]   WR_DATA,
    input  logic [5:0]          RD_ADDR_A,
    input  logic [5:0]          RD_ADDR_B,
    output logic [DATA_W-1:0]   RD_DATA_A,
    output logic [DATA_W-1:0]   RD_DATA_B,
    output logic                RD_VLD_A,
    output logic                RD_VLD_B,
    output logic                SEL_ERR,
    output logic [ERRCNT_W-1:0] ERR_CNT
);
    localparam int         N    = 64;
    localparam logic [5:0] ZIDX = 6'(ZERO_IDX);

    logic                     multi_hot, one_hot, wr_zero, byp_en;
    logic [5:0]               wr_idx;
    logic [N-1:0]             we;
    logic [N-1:0][DATA_W-1:0] ent_q;
    logic [N-1:0]             ent_wr;
    logic [1:0][5:0]          rd_addr;
    logic [1:0][DATA_W-1:0]   rd_data;
    logic [1:0]               rd_vld;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    always_comb begin
        multi_hot = |(WR_SEL & (WR_SEL - 64'd1));
        one_hot   = (|WR_SEL) & ~multi_hot;
        wr_idx    = '0;
        for (int i = 0; i < N; i++)
            if (WR_SEL[i]) wr_idx = wr_idx | 6'(i);
        wr_zero   = (ZERO_EN != 0) && (wr_idx == ZIDX);
        byp_en    = one_hot & ~wr_zero;
        we        = one_hot ? WR_SEL : '0;
        if (ZERO_EN != 0) we[ZIDX] = 1'b0;
    end

    for (genvar g = 0; g < N; g++) begin : g_ent
        ohrb_entry #(.DATA_W(DATA_W)) u_ent (
            .CLK(CLK), .RESET(RESET), .we(we[g]), .wdata(WR_DATA),
            .q(ent_q[g]), .written(ent_wr[g])
        );
    end

    assign rd_addr = {RD_ADDR_B, RD_ADDR_A};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        ohrb_rdport #(.N(N), .DATA_W(DATA_W), .ZERO_EN(ZERO_EN), .ZERO_IDX(ZERO_IDX)) u_rd (
            .CLK(CLK), .RESET(RESET), .addr(rd_addr[p]), .ent_q(ent_q), .ent_wr(ent_wr),
            .byp_en(byp_en), .byp_idx(wr_idx), .byp_data(WR_DATA),
            .rd_data(rd_data[p]), .rd_vld(rd_vld[p])
        );
    end

    assign RD_DATA_A = rd_data[0];
    assign RD_DATA_B = rd_data[1];
    assign RD_VLD_A  = rd_vld[0];
    assign RD_VLD_B  = rd_vld[1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEL_ERR <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            SEL_ERR <= multi_hot;
            if (multi_hot && ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERRCNT_W'(1);
        end
    end
endmodule
